lcd_byte_writer: RTL and testbench

//  Downstream of the LCD power-on init controller on the 4-bit character-LCD bus.

---
 rtl/lcd_byte_writer.sv | 146 ++++++++++++++
 tb/tb_lcd_byte_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit bus byte writer: sends each accepted byte as two nibbles.
// Optional macro LCD_CLEAR_WAIT_EN: long post-wait for clear/home commands.
module lcd_byte_writer #(
   parameter int unsigned SETUP_CYCLES      = 2,
   parameter int unsigned E_HIGH_CYCLES     = 12,
   parameter int unsigned NIBBLE_GAP_CYCLES = 50,
   parameter int unsigned BYTE_WAIT_CYCLES  = 2000,
   parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iInitDone,
   input  logic       iValid,
   input  logic [7:0] iData,
   input  logic       iRS,
   output logic       oReady,
   output logic       oByteDone,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic [3:0] oLCD_Data
);

   localparam logic [16:0] SETUP_L = 17'(SETUP_CYCLES - 1);
   localparam logic [16:0] HIGH_L  = 17'(E_HIGH_CYCLES - 1);
   localparam logic [16:0] GAP_L   = 17'(NIBBLE_GAP_CYCLES - 1);
   localparam logic [16:0] BYTE_L  = 17'(BYTE_WAIT_CYCLES - 1);
   localparam logic [16:0] CLEAR_L = 17'(CLEAR_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP_SETUP,
      S_UP_PULSE,
      S_UP_GAP,
      S_LO_SETUP,
      S_LO_PULSE,
      S_BYTE_WAIT
   } state_e;

   state_e      state_q, state_d;
   logic [16:0] cnt_q, cnt_d;
   logic [7:0]  byte_q;
   logic        rs_q;
   logic        done_q, done_d;
   logic        accept;
   logic        clr_sel;
   logic [16:0] wait_l;

`ifdef LCD_CLEAR_WAIT_EN
   logic clr_q, clr_d;

   assign clr_d   = ~iRS && ((iData == 8'h01) || (iData == 8'h02));
   assign clr_sel = clr_q;
`else
   // Constant select: the clear-wait limit folds away entirely.
   assign clr_sel = 1'b0;
`endif

   assign wait_l = clr_sel ? CLEAR_L : BYTE_L;

   // Ready is held low while reset is asserted so reset outputs are all zero.
   assign oReady    = (state_q == S_IDLE) && iInitDone && !Reset;
   assign accept    = iValid && oReady;
   assign oByteDone = done_q;

   // Next-state decode: each state exits once its counter reaches N-1.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE:      if (accept) state_d = S_UP_SETUP;
         S_UP_SETUP:  if (cnt_q == SETUP_L) state_d = S_UP_PULSE;
         S_UP_PULSE:  if (cnt_q == HIGH_L) state_d = S_UP_GAP;
         S_UP_GAP:    if (cnt_q == GAP_L) state_d = S_LO_SETUP;
         S_LO_SETUP:  if (cnt_q == SETUP_L) state_d = S_LO_PULSE;
         S_LO_PULSE:  if (cnt_q == HIGH_L) state_d = S_BYTE_WAIT;
         S_BYTE_WAIT: begin
            if (cnt_q == wait_l) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default:     state_d = S_IDLE;
      endcase
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 17'd1;
      end
   end

   // LCD bus drive decoded from the current state.
   always_comb begin
      oLCD_Enabled        = 1'b0;
      oLCD_RegisterSelect = 1'b0;
      oLCD_Data           = 4'h0;
      unique case (state_q)
         S_UP_SETUP, S_UP_GAP: begin
            oLCD_RegisterSelect = rs_q;
            oLCD_Data           = byte_q[7:4];
         end
         S_UP_PULSE: begin
            oLCD_Enabled        = 1'b1;
            oLCD_RegisterSelect = rs_q;
            oLCD_Data           = byte_q[7:4];
         end
         S_LO_SETUP, S_BYTE_WAIT: begin
            oLCD_RegisterSelect = rs_q;
            oLCD_Data           = byte_q[3:0];
         end
         S_LO_PULSE: begin
            oLCD_Enabled        = 1'b1;
            oLCD_RegisterSelect = rs_q;
            oLCD_Data           = byte_q[3:0];
         end
         default: begin
            oLCD_Enabled        = 1'b0;
         end
      endcase
   end

   // State, dwell counter, done pulse and byte latches.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         byte_q  <= '0;
         rs_q    <= 1'b0;
`ifdef LCD_CLEAR_WAIT_EN
         clr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (accept) begin
            byte_q <= iData;
            rs_q   <= iRS;
`ifdef LCD_CLEAR_WAIT_EN
            clr_q  <= clr_d;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer.
// Expected bus activity is derived from the nibble timeline arithmetic.
module tb_lcd_byte_writer;

   localparam int S  = 2;
   localparam int H  = 12;
   localparam int G  = 50;
   localparam int W  = 2000;
   localparam int CW = 82000;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iInitDone;
   logic       iValid;
   logic [7:0] iData;
   logic       iRS;
   logic       oReady;
   logic       oByteDone;
   logic       oLCD_Enabled;
   logic       oLCD_RegisterSelect;
   logic [3:0] oLCD_Data;

   int nchk = 0;
   int nfail = 0;

   lcd_byte_writer dut (
      .Clock              (Clock),
      .Reset              (Reset),
      .iInitDone          (iInitDone),
      .iValid             (iValid),
      .iData              (iData),
      .iRS                (iRS),
      .oReady             (oReady),
      .oByteDone          (oByteDone),
      .oLCD_Enabled       (oLCD_Enabled),
      .oLCD_RegisterSelect(oLCD_RegisterSelect),
      .oLCD_Data          (oLCD_Data)
   );

   always #5 Clock = ~Clock;

   function automatic logic [7:0] obs();
      return {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data,
              oByteDone, oReady};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      nchk++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int wait_n(input logic [7:0] b, input logic rs);
`ifdef LCD_CLEAR_WAIT_EN
      if (!rs && (b == 8'h01 || b == 8'h02)) return CW;
`endif
      return W;
   endfunction

   // Expected {E, RS, data, done, ready} k cycles after the accept edge.
   function automatic logic [7:0] model(input int k, input logic [7:0] b,
                                        input logic rs, input int wn,
                                        input logic init);
      int  busy;
      logic e;
      logic [3:0] d;
      busy = 2 * S + 2 * H + G + wn;
      if (k > busy) return {1'b0, 1'b0, 4'h0, 1'b1, init};
      e = (k > S && k <= S + H) ||
          (k > 2 * S + H + G && k <= 2 * S + 2 * H + G);
      d = (k <= S + H + G) ? b[7:4] : b[3:0];
      return {e, rs, d, 2'b00};
   endfunction

   task automatic issue(input logic [7:0] b, input logic rs);
      for (int i = 0; i < 5000 && !oReady; i++) @(negedge Clock);
      chk("issue_ready", oReady, 1);
      iValid = 1'b1;
      iData  = b;
      iRS    = rs;
   endtask

   task automatic xfer(input logic [7:0] b, input logic rs,
                       input bit keep, input int drop_at);
      int   wn;
      int   busy;
      int   rises;
      logic pe;
      wn    = wait_n(b, rs);
      busy  = 2 * S + 2 * H + G + wn;
      rises = 0;
      pe    = 1'b0;
      @(posedge Clock);
      for (int k = 1; k <= busy + 1; k++) begin
         @(negedge Clock);
         if (k == 1 && !keep) iValid = 1'b0;
         if (k == drop_at) iInitDone = 1'b0;
         chk($sformatf("xfer_%02h_k%0d", b, k), obs(),
             model(k, b, rs, wn, iInitDone));
         if (oLCD_Enabled && !pe) rises++;
         pe = oLCD_Enabled;
      end
      chk($sformatf("e_pulses_%02h", b), rises, 2);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rr;
      int         nrand;

      Reset     = 1'b1;
      iInitDone = 1'b1;
      iValid    = 1'b1;
      iData     = 8'h28;
      iRS       = 1'b0;
      repeat (3) begin
         @(posedge Clock);
         @(negedge Clock);
         chk("reset_outs", obs(), 0);
      end
      iValid = 1'b0;
      Reset  = 1'b0;
      repeat (100) begin
         @(negedge Clock);
         chk("idle_e", oLCD_Enabled, 0);
      end
      chk("ready_after_reset", oReady, 1);

      iInitDone = 1'b0;
      iValid    = 1'b1;
      repeat (500) begin
         @(negedge Clock);
         chk("no_init", {oReady, oLCD_Enabled}, 0);
      end
      iValid    = 1'b0;
      iInitDone = 1'b1;

      issue(8'h28, 1'b0);
      xfer(8'h28, 1'b0, 1'b0, 0);

      issue(8'h41, 1'b1);
      xfer(8'h41, 1'b1, 1'b1, 0);
      rb = 8'($urandom);
      issue(rb, 1'b1);
      xfer(rb, 1'b1, 1'b0, 0);

      issue(8'h01, 1'b0);
      xfer(8'h01, 1'b0, 1'b0, 0);

      issue(8'h80, 1'b1);
      xfer(8'h80, 1'b1, 1'b0, 100);
      repeat (5) begin
         @(negedge Clock);
         chk("ready_init_low", oReady, 0);
      end
      iInitDone = 1'b1;
      @(negedge Clock);
      chk("ready_init_back", oReady, 1);

      issue(8'h55, 1'b0);
      @(posedge Clock);
      @(negedge Clock);
      iValid = 1'b0;
      repeat (4) @(negedge Clock);
      chk("mid_pulse_e", oLCD_Enabled, 1);
      Reset = 1'b1;
      @(negedge Clock);
      chk("reset_mid_pulse", obs(), 0);
      Reset = 1'b0;
      @(negedge Clock);
      chk("ready_post_reset", oReady, 1);
      issue(8'h0C, 1'b0);
      xfer(8'h0C, 1'b0, 1'b0, 0);

`ifdef LCD_CLEAR_WAIT_EN
      nrand = 0;
`else
      nrand = 3;
`endif
      for (int i = 0; i < nrand; i++) begin
         rb = 8'($urandom);
         rr = 1'($urandom);
         if (!rr && (rb == 8'h01 || rb == 8'h02)) rb = rb ^ 8'h10;
         issue(rb, rr);
         xfer(rb, rr, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule
